// File: rtl/m_spi_fifo_tx.sv
// Buffered SPI transmitter for the ST7789 path: 18-bit {dc, wide, data} FIFO feeding a clock-divided MSB-first serializer.
// Push-to-CS-low takes 2 cycles; o_ready drops at full and any push while full is dropped.

module m_spi_fifo_tx_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   empty,
  output logic                   rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_push = push && rdy;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // rdy is a flop so o_ready never depends combinationally on the pop side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      rdy   <= (level_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module m_spi_fifo_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 1,
  parameter bit CPOL       = 1'b1
) (
  input  logic                        w_clk,
  input  logic                        w_rst,
  input  logic                        i_valid,
  input  logic                        i_dc,
  input  logic                        i_wide,
  input  logic [15:0]                 i_data,
  output logic                        o_ready,
  output logic                        o_SCL,
  output logic                        o_SDA,
  output logic                        o_DC,
  output logic                        o_CS,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);
  localparam int            HW        = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  state_t state_nxt;

  logic [17:0]                 fifo_dat;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] level_nxt;
  logic                        start;
  logic                        half_end;
  logic                        word_end;
  logic [4:0]                  last_bit;
  logic [15:0]                 load_dat;

  logic [HW-1:0] half_cnt;
  logic [HW-1:0] half_cnt_nxt;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_cnt_nxt;
  logic [15:0]   shreg;
  logic [15:0]   shreg_nxt;
  logic          wide_q;
  logic          wide_nxt;
  logic          scl_nxt;
  logic          sda_nxt;
  logic          dc_nxt;
  logic          cs_nxt;
  logic          busy_nxt;

  m_spi_fifo_tx_fifo #(
    .WIDTH (18),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (w_clk),
    .rst       (w_rst),
    .push      (i_valid),
    .push_dat  ({i_dc, i_wide, i_data}),
    .pop       (start),
    .pop_dat   (fifo_dat),
    .empty     (fifo_empty),
    .rdy       (o_ready),
    .level     (o_level),
    .level_nxt (level_nxt)
  );

  // 8-bit words are left-aligned so the serializer always shifts out of bit 15
  assign load_dat = fifo_dat[16] ? fifo_dat[15:0] : {fifo_dat[7:0], 8'h00};
  assign last_bit = wide_q ? 5'd15 : 5'd7;
  assign half_end = (half_cnt == HALF_LAST);
  assign word_end = (state == SHIFT) && half_end && (o_SCL == CPOL) && (bit_cnt == last_bit);
  assign start    = !fifo_empty && ((state == IDLE) || word_end);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SHIFT;
      SHIFT:   if (word_end && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    half_cnt_nxt = half_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    wide_nxt     = wide_q;
    scl_nxt      = o_SCL;
    sda_nxt      = o_SDA;
    dc_nxt       = o_DC;
    cs_nxt       = o_CS;
    if (start) begin
      half_cnt_nxt = '0;
      bit_cnt_nxt  = '0;
      shreg_nxt    = {load_dat[14:0], 1'b0};
      wide_nxt     = fifo_dat[16];
      scl_nxt      = ~CPOL;
      sda_nxt      = load_dat[15];
      dc_nxt       = fifo_dat[17];
      cs_nxt       = 1'b0;
    end else if (state == SHIFT) begin
      if (!half_end) begin
        half_cnt_nxt = half_cnt + HW'(1);
      end else begin
        half_cnt_nxt = '0;
        if (o_SCL != CPOL) begin
          scl_nxt = CPOL;
        end else if (bit_cnt == last_bit) begin
          bit_cnt_nxt = '0;
          scl_nxt     = CPOL;
          sda_nxt     = 1'b1;
          cs_nxt      = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          shreg_nxt   = {shreg[14:0], 1'b0};
          sda_nxt     = shreg[15];
          scl_nxt     = ~CPOL;
        end
      end
    end else begin
      scl_nxt = CPOL;
      cs_nxt  = 1'b1;
    end
    busy_nxt = (state_nxt == SHIFT) || (level_nxt != '0);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      wide_q   <= 1'b0;
      o_SCL    <= CPOL;
      o_SDA    <= 1'b1;
      o_DC     <= 1'b0;
      o_CS     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      half_cnt <= half_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      wide_q   <= wide_nxt;
      o_SCL    <= scl_nxt;
      o_SDA    <= sda_nxt;
      o_DC     <= dc_nxt;
      o_CS     <= cs_nxt;
      o_busy   <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_m_spi_fifo_tx.sv
// Bench for m_spi_fifo_tx: three instances (CLK_DIV 1/2/8, CPOL 1/0/1) share one stimulus stream and
// are compared every cycle against a word-timeline model (start = max(push+1, previous end)).

module tb_m_spi_fifo_tx;
  localparam int N     = 3;
  localparam int DEPTH = 16;

  logic        w_clk   = 1'b0;
  logic        w_rst   = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_dc    = 1'b0;
  logic        i_wide  = 1'b0;
  logic [15:0] i_data  = '0;

  logic       rdy  [N];
  logic       scl  [N];
  logic       sda  [N];
  logic       dc   [N];
  logic       cs   [N];
  logic       busy [N];
  logic [4:0] lvl  [N];

  always #5 w_clk = ~w_clk;

  m_spi_fifo_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(1), .CPOL(1'b1)) u0 (
    .w_clk(w_clk), .w_rst(w_rst), .i_valid(i_valid), .i_dc(i_dc), .i_wide(i_wide), .i_data(i_data),
    .o_ready(rdy[0]), .o_SCL(scl[0]), .o_SDA(sda[0]), .o_DC(dc[0]), .o_CS(cs[0]),
    .o_busy(busy[0]), .o_level(lvl[0]));

  m_spi_fifo_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(2), .CPOL(1'b0)) u1 (
    .w_clk(w_clk), .w_rst(w_rst), .i_valid(i_valid), .i_dc(i_dc), .i_wide(i_wide), .i_data(i_data),
    .o_ready(rdy[1]), .o_SCL(scl[1]), .o_SDA(sda[1]), .o_DC(dc[1]), .o_CS(cs[1]),
    .o_busy(busy[1]), .o_level(lvl[1]));

  m_spi_fifo_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(8), .CPOL(1'b1)) u2 (
    .w_clk(w_clk), .w_rst(w_rst), .i_valid(i_valid), .i_dc(i_dc), .i_wide(i_wide), .i_data(i_data),
    .o_ready(rdy[2]), .o_SCL(scl[2]), .o_SDA(sda[2]), .o_DC(dc[2]), .o_CS(cs[2]),
    .o_busy(busy[2]), .o_level(lvl[2]));

  // reference model state, per instance
  logic [17:0] mq [N][32];
  int          hd [N];
  int          tl [N];
  int          ws [N];
  int          we [N];
  logic [17:0] cw [N];
  logic        ldc [N];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  function automatic int div_of(int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic cpol_of(int k);
    return (k != 1);
  endfunction

  task automatic check(string tag, logic [10:0] got, logic [10:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got={cs,scl,sda,dc,busy,rdy,lvl}=%b exp=%b", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hd[k]  = 0;
      tl[k]  = 0;
      ws[k]  = 0;
      we[k]  = 0;
      cw[k]  = '0;
      ldc[k] = 1'b0;
    end
  endtask

  // one rising edge: acceptance uses the occupancy seen before the edge, pop only sees older words
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      int   occ;
      logic acc;
      occ = tl[k] - hd[k];
      acc = i_valid && (occ < DEPTH);
      if (cyc >= we[k] && occ != 0) begin
        cw[k]  = mq[k][hd[k] % 32];
        hd[k]  = hd[k] + 1;
        ws[k]  = cyc;
        we[k]  = cyc + (cw[k][16] ? 16 : 8) * 2 * div_of(k);
        ldc[k] = cw[k][17];
      end
      if (acc) begin
        mq[k][tl[k] % 32] = {i_dc, i_wide, i_data};
        tl[k] = tl[k] + 1;
      end
    end
  endtask

  function automatic logic [10:0] expect_outs(int k);
    logic        e_cs, e_scl, e_sda, e_dc, e_busy, e_rdy, act, pol;
    int          occ, ph, b, d;
    logic [15:0] dat;
    d     = div_of(k);
    pol   = cpol_of(k);
    occ   = tl[k] - hd[k];
    act   = (ws[k] <= cyc) && (cyc < we[k]);
    e_cs  = !act;
    e_scl = pol;
    e_sda = 1'b1;
    e_dc  = ldc[k];
    if (act) begin
      ph    = cyc - ws[k];
      b     = ph / (2 * d);
      dat   = cw[k][15:0];
      e_scl = ((ph % (2 * d)) < d) ? !pol : pol;
      e_sda = cw[k][16] ? dat[15 - b] : dat[7 - b];
    end
    e_busy = act || (occ != 0);
    e_rdy  = (occ < DEPTH);
    return {e_cs, e_scl, e_sda, e_dc, e_busy, e_rdy, 5'(occ)};
  endfunction

  task automatic compare_all(string tag);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_u%0d", tag, k),
            {cs[k], scl[k], sda[k], dc[k], busy[k], rdy[k], lvl[k]}, expect_outs(k));
  endtask

  task automatic step();
    @(posedge w_clk);
    cyc++;
    model_edge();
    @(negedge w_clk);
    compare_all("outs");
  endtask

  task automatic idle(int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_word(logic d, logic w, logic [15:0] v);
    i_valid = 1'b1;
    i_dc    = d;
    i_wide  = w;
    i_data  = v;
    step();
    i_valid = 1'b0;
  endtask

  // asynchronous reset between edges; outputs must be at reset values right away
  task automatic do_reset();
    #2 w_rst = 1'b1;
    i_valid = 1'b0;
    #1 model_reset();
    compare_all("rst_async");
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    compare_all("rst_hold");
    w_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 w_rst = 1'b1;
    #1 compare_all("rst_init");
    @(negedge w_clk);
    w_rst = 1'b0;

    push_word(1'b0, 1'b0, 16'h002A);
    idle(300);

    push_word(1'b1, 1'b1, 16'hF800);
    push_word(1'b1, 1'b1, 16'h07E0);
    push_word(1'b1, 1'b1, 16'h001F);
    idle(800);

    push_word(1'b0, 1'b0, 16'h002C);
    push_word(1'b1, 1'b1, 16'hFFFF);
    idle(450);

    push_word(1'b1, 1'b1, 16'hA5C3);
    push_word(1'b0, 1'b0, 16'h0055);
    idle(21);
    do_reset();
    idle(40);

    for (int i = 0; i < 20; i++) push_word(1'(i), 1'b1, 16'($urandom));
    idle(4500);

    for (int i = 0; i < 3000; i++) begin
      i_valid = ($urandom_range(0, 99) < 35);
      i_dc    = 1'($urandom);
      i_wide  = 1'($urandom);
      i_data  = 16'($urandom);
      step();
    end
    idle(4700);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
